// File: rtl/pwr_seq_ctrl.sv
// ============================================================================
// pwr_seq_ctrl : power-sequencing controller for one switchable power domain
// Rev 1.0
// ============================================================================
`default_nettype none

module pwr_seq_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       pwr_ack,
  input  logic       err_clr,
  output logic       pwr_on,
  output logic       clk_en,
  output logic       iso_en,
  output logic       save,
  output logic       restore,
  output logic [3:0] state,
  output logic       busy,
  output logic       err
);

  localparam int CNT_MAX = (SETTLE_CYCLES > ACK_TIMEOUT) ? SETTLE_CYCLES : ACK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] ACK_LAST    = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);

  localparam logic [3:0] ST_ON       = 4'd0;
  localparam logic [3:0] ST_CLK_STOP = 4'd1;
  localparam logic [3:0] ST_ISOLATE  = 4'd2;
  localparam logic [3:0] ST_SAVE     = 4'd3;
  localparam logic [3:0] ST_PWR_OFF  = 4'd4;
  localparam logic [3:0] ST_OFF      = 4'd5;
  localparam logic [3:0] ST_PWR_UP   = 4'd6;
  localparam logic [3:0] ST_RESTORE  = 4'd7;
  localparam logic [3:0] ST_DEISO    = 4'd8;
  localparam logic [3:0] ST_CLK_RUN  = 4'd9;

  logic [3:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          settle_done;
  logic          ack_expired;
  logic          timeout;

  assign settle_done = (cnt >= SETTLE_LAST);
  assign ack_expired = (cnt >= ACK_LAST);

  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    case (state)
      ST_ON:       if (!wake_req && sleep_req) state_nxt = ST_CLK_STOP;
      ST_CLK_STOP: if (settle_done) state_nxt = ST_ISOLATE;
      ST_ISOLATE:  if (settle_done) state_nxt = ST_SAVE;
      ST_SAVE:     if (settle_done) state_nxt = ST_PWR_OFF;
      ST_PWR_OFF: begin
        // a real ack wins over a timeout landing on the same cycle
        if (!pwr_ack) begin
          state_nxt = ST_OFF;
        end else if (ack_expired) begin
          state_nxt = ST_OFF;
          timeout   = 1'b1;
        end
      end
      ST_OFF:      if (wake_req) state_nxt = ST_PWR_UP;
      ST_PWR_UP: begin
        if (pwr_ack) begin
          state_nxt = ST_RESTORE;
        end else if (ack_expired) begin
          state_nxt = ST_OFF;
          timeout   = 1'b1;
        end
      end
      ST_RESTORE:  if (settle_done) state_nxt = ST_DEISO;
      ST_DEISO:    if (settle_done) state_nxt = ST_CLK_RUN;
      ST_CLK_RUN:  if (settle_done) state_nxt = ST_ON;
      default:     state_nxt = ST_ON;
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (cnt == CNT_SAT) begin
      cnt_nxt = cnt;
    end else begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ON;
      cnt     <= '0;
      pwr_on  <= 1'b1;
      clk_en  <= 1'b1;
      iso_en  <= 1'b0;
      save    <= 1'b0;
      restore <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pwr_on  <= !(state_nxt == ST_PWR_OFF || state_nxt == ST_OFF);
      clk_en  <= (state_nxt == ST_ON) || (state_nxt == ST_CLK_RUN);
      iso_en  <= (state_nxt >= ST_ISOLATE) && (state_nxt <= ST_RESTORE);
      save    <= (state_nxt == ST_SAVE) && (state != ST_SAVE);
      restore <= (state_nxt == ST_RESTORE) && (state != ST_RESTORE);
      busy    <= !(state_nxt == ST_ON || state_nxt == ST_OFF);
      if (timeout) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/pwr_seq_ctrl.md
Name: pwr_seq_ctrl

Overview:
- Power-sequencing controller directly upstream of a switchable power domain.
- Drives the domain's pwr_on (power-switch enable) plus its clock-gate enable, isolation enable and retention save/restore strobes.
- Orders these outputs safely on sleep/wake requests and waits for the power-switch acknowledge.
- Sits in the always-on domain, one instance per switchable domain.

Parameters:
- SETTLE_CYCLES, 2, dwell in each timed sequencing state; legal range 1..255.
- ACK_TIMEOUT, 16, max cycles to wait for pwr_ack in PWR_OFF or PWR_UP before error; legal range 2..1023.

Ports:
- clk in 1 system clock (always-on); all logic on rising edge.
- rst_n in 1 asynchronous active-low reset.
- sleep_req in 1 level request to power the domain down.
- wake_req in 1 level request to power the domain up.
- pwr_ack in 1 power-switch status; 1 means the domain supply is good. Already synchronised.
- err_clr in 1 one-cycle pulse; clears err.
- pwr_on out 1 power-switch enable to the domain.
- clk_en out 1 domain clock-gate enable.
- iso_en out 1 output isolation enable.
- save out 1 one-cycle retention save strobe.
- restore out 1 one-cycle retention restore strobe.
- state out 4 current state encoding.
- busy out 1 high in any state other than ON or OFF.
- err out 1 sticky ack-timeout flag.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- State encoding: ON=0, CLK_STOP=1, ISOLATE=2, SAVE=3, PWR_OFF=4, OFF=5, PWR_UP=6, RESTORE=7, DEISO=8, CLK_RUN=9. Codes 10-15 are illegal and recover to ON on the next edge.
- Reset (async assert, sync use after deassert):
  - state=ON, pwr_on=1, clk_en=1, iso_en=0.
  - save=0, restore=0, err=0, dwell/timeout counter=0.
- All outputs are registered and update on the same edge as state. No combinational path from input to output.
- Output levels per state, given as pwr_on/iso_en/clk_en:
  - ON 1/0/1, CLK_STOP 1/0/0, ISOLATE 1/1/0, SAVE 1/1/0, PWR_OFF 0/1/0.
  - OFF 0/1/0, PWR_UP 1/1/0, RESTORE 1/1/0, DEISO 1/0/0, CLK_RUN 1/0/1.
- save is high only on the first cycle of SAVE. restore is high only on the first cycle of RESTORE.
- Transitions:
  - ON: wake_req=1 → stay ON (wake has priority). Else sleep_req=1 → CLK_STOP.
  - CLK_STOP → ISOLATE → SAVE: each state lasts exactly SETTLE_CYCLES cycles; counter resets on entry.
  - SAVE → PWR_OFF after SETTLE_CYCLES.
  - PWR_OFF: pwr_ack sampled 0 → OFF. ACK_TIMEOUT cycles in state without ack → OFF and err←1.
  - OFF: wake_req=1 → PWR_UP; sleep_req is ignored here.
  - PWR_UP: pwr_ack sampled 1 → RESTORE. ACK_TIMEOUT cycles without ack → OFF (pwr_on drops) and err←1.
  - RESTORE → DEISO → CLK_RUN: each lasts SETTLE_CYCLES cycles.
  - CLK_RUN → ON after SETTLE_CYCLES.
- Minimum dwell in PWR_OFF and PWR_UP is 1 cycle: ack is sampled from the first cycle in state onward.
- Requests are ignored while busy and are not queued. A request still held when ON or OFF is reached acts on the next edge, so a held sleep_req loops a full sequence again.
- err sets on timeout. err_clr clears it. If err_clr and a new timeout occur on the same edge, set wins.
- Reset asserted mid-sequence: all outputs return to reset values immediately (pwr_on=1, iso_en=0, clk_en=1), regardless of pwr_ack.
- Counter width: $clog2(max(SETTLE_CYCLES, ACK_TIMEOUT)+1). The counter saturates and never wraps.

Test Plan:
- Reset release, no requests, 20 cycles → state=0, pwr_on=1, clk_en=1, iso_en=0, busy=0, save/restore never pulse.
- Power-down, SETTLE=2: sleep_req sampled at edge E → clk_en=0 after E, iso_en=1 after E+2, save pulse exactly in cycle after E+4, pwr_on=0 after E+6. Ack model drops pwr_ack 3 cycles later → state=OFF, busy=0.
- Power-up from OFF: wake_req, ack rises 2 cycles after pwr_on → restore single pulse, iso_en=0 one SETTLE after restore, clk_en=1 after another SETTLE, then state=ON. iso_en must be 1 whenever pwr_on=0.
- Timeout: pwr_ack held 1 forever in PWR_OFF → OFF after 16 cycles, err=1. Then err_clr pulse → err=0. Then wake with ack stuck 0 → back to OFF, pwr_on=0, err=1.
- Simultaneous sleep_req=wake_req=1 in ON → no transition for 10 cycles. sleep_req pulse during PWR_UP → ignored, sequence completes to ON.
- rst_n asserted while in SAVE → pwr_on=1, iso_en=0, clk_en=1, state=0 without waiting for a clock edge.
